// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tristate bus. Registered one-hot grant drives each requester's output-enable.
// Latency: grant 1 cycle after req from idle; exactly TURN all-released cycles between owners.
// Backpressure: requesters hold req until served; hold limit forces release when others are waiting.
module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 4,
    parameter int TURN     = 1
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             turnaround
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURN + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic             busy_q, busy_d;
    logic             ta_q, ta_d;

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic             others_pending;

    // Search starts just after the last owner, so the previous owner ends up lowest priority.
    always_comb begin : rr_pick
        int               j;
        logic [IDX_W-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            j = int'(last_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IDX_W'(j);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign others_pending = |(req & ~grant_q);

    always_comb begin : next_state
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        turn_d  = turn_q;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d          = ST_GRANT;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    last_d           = win_idx;
                    hold_d           = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (!req[owner_q] || (hold_q == HOLD_W'(MAX_HOLD) && others_pending)) begin
                    state_d = ST_TURN;
                    grant_d = '0;
                    hold_d  = '0;
                    turn_d  = TURN_W'(1);
                end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                if (turn_q == TURN_W'(TURN)) begin
                    turn_d = '0;
                    if (win_vld) begin
                        state_d          = ST_GRANT;
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        owner_d          = win_idx;
                        last_d           = win_idx;
                        hold_d           = HOLD_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                hold_d  = '0;
                turn_d  = '0;
            end
        endcase

        busy_d = |grant_d;
        ta_d   = (state_d == ST_TURN);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(N - 1);
            hold_q  <= '0;
            turn_q  <= '0;
            busy_q  <= 1'b0;
            ta_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            busy_q  <= busy_d;
            ta_q    <= ta_d;
        end
    end

    assign grant      = grant_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign turnaround = ta_q;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed vector table, hand sequences, and randomized run against a reference model.
module tb_tristate_bus_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int TURN2    = 2;

    logic       clock = 1'b0;
    logic       reset_;
    logic [3:0] req, req2;
    logic [3:0] grant, grant2;
    logic [1:0] owner, owner2;
    logic       busy, busy2, ta, ta2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tristate_bus_arbiter #(.N(N), .IDX_W(2), .MAX_HOLD(MAX_HOLD), .TURN(1)) dut (
        .clock(clock), .reset_(reset_), .req(req),
        .grant(grant), .owner(owner), .busy(busy), .turnaround(ta)
    );

    tristate_bus_arbiter #(.N(N), .IDX_W(2), .MAX_HOLD(MAX_HOLD), .TURN(TURN2)) dut2 (
        .clock(clock), .reset_(reset_), .req(req2),
        .grant(grant2), .owner(owner2), .busy(busy2), .turnaround(ta2)
    );

    typedef struct {
        bit         rst;
        logic [3:0] r;
        logic [3:0] g;
        logic [1:0] o;
        bit         b;
        bit         t;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] o,
                           input bit b, input bit t);
        chk({name, ".grant"}, 32'(grant), 32'(g));
        chk({name, ".busy"}, 32'(busy), 32'(b));
        chk({name, ".turn"}, 32'(ta), 32'(t));
        if (b) chk({name, ".owner"}, 32'(owner), 32'(o));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_ = 1'b0;
        req    = '0;
        req2   = '0;
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clock);
        req = r;
        @(posedge clock);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Reference model state: owner index (-1 = nobody), last owner, grant-cycle count, released cycles left.
    int m_own, m_last, m_held, m_gap;

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_gap > 0) begin
            if (m_gap == 1) begin
                w = pick(r, m_last);
                if (w >= 0) begin
                    m_own = w; m_last = w; m_held = 1;
                end
            end
            m_gap--;
        end else if (m_own < 0) begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_own = w; m_last = w; m_held = 1;
            end
        end else begin
            logic [3:0] others;
            others = r;
            others[m_own] = 1'b0;
            if (!r[m_own] || (m_held == MAX_HOLD && others != 0)) begin
                m_own = -1;
                m_gap = TURN2;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end
    endtask

    initial begin
        logic [3:0] eg, last_nz, pend_grant;
        int zero_run, ta_run, pend_run;

        // Test 1: single request; Test 2: simultaneous requests served 0,1,3.
        tbl.push_back('{1, 4'b0100, 4'b0100, 2'd2, 1, 0});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd0, 0, 1});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd0, 0, 0});
        tbl.push_back('{1, 4'b1011, 4'b0001, 2'd0, 1, 0});
        tbl.push_back('{0, 4'b1010, 4'b0000, 2'd0, 0, 1});
        tbl.push_back('{0, 4'b1010, 4'b0010, 2'd1, 1, 0});
        tbl.push_back('{0, 4'b1000, 4'b0000, 2'd0, 0, 1});
        tbl.push_back('{0, 4'b1000, 4'b1000, 2'd3, 1, 0});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd0, 0, 1});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd0, 0, 0});

        reset_ = 1'b1;
        req    = '0;
        req2   = '0;
        #1 reset_ = 1'b0;
        #11;
        chk("reset.grant", 32'(grant), 0);
        chk("reset.owner", 32'(owner), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.turn", 32'(ta), 0);
        chk("reset.grant2", 32'(grant2), 0);
        @(negedge clock);
        reset_ = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].r);
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].o, tbl[i].b, tbl[i].t);
        end

        // Test 3: preemption after MAX_HOLD cycles, then the waiting requester, then back.
        do_reset();
        step(4'b0001);
        chk_out("pre.c1", 4'b0001, 2'd0, 1, 0);
        for (int c = 2; c <= MAX_HOLD; c++) begin
            step(4'b0101);
            chk_out($sformatf("pre.c%0d", c), 4'b0001, 2'd0, 1, 0);
        end
        step(4'b0101);
        chk_out("pre.gap", 4'b0000, 2'd0, 0, 1);
        step(4'b0101);
        chk_out("pre.req2", 4'b0100, 2'd2, 1, 0);
        step(4'b0001);
        chk_out("pre.gap2", 4'b0000, 2'd0, 0, 1);
        step(4'b0001);
        chk_out("pre.back", 4'b0001, 2'd0, 1, 0);

        // Test 4: lone holder keeps the bus with no gaps.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(4'b0001);
            chk_out($sformatf("lone.c%0d", c), 4'b0001, 2'd0, 1, 0);
        end

        // Test 5: asynchronous reset while granted.
        do_reset();
        step(4'b1000);
        chk_out("rst.pre", 4'b1000, 2'd3, 1, 0);
        @(negedge clock);
        reset_ = 1'b0;
        #1;
        chk("rst.async.grant", 32'(grant), 0);
        chk("rst.async.busy", 32'(busy), 0);
        @(negedge clock);
        req    = 4'b1001;
        reset_ = 1'b1;
        @(posedge clock);
        #1;
        chk_out("rst.after", 4'b0001, 2'd0, 1, 0);

        // Test 6: random requests on the TURN=2 instance against the reference model.
        do_reset();
        m_own = -1; m_last = N - 1; m_held = 0; m_gap = 0;
        last_nz = '0; zero_run = 0; ta_run = 0; pend_run = 0; pend_grant = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) req2[b] = ~req2[b];
            end
            if (grant2 != 0 && (req2 & ~grant2) != 0) begin
                pend_run = (grant2 == pend_grant) ? pend_run + 1 : 1;
                pend_grant = grant2;
                chk("rand.hold_limit", 32'(pend_run <= MAX_HOLD), 1);
            end else begin
                pend_run = 0;
                pend_grant = '0;
            end
            @(posedge clock);
            model_step(req2);
            #1;
            eg = '0;
            if (m_own >= 0) eg[m_own] = 1'b1;
            chk($sformatf("rand%0d.grant", c), 32'(grant2), 32'(eg));
            chk($sformatf("rand%0d.turn", c), 32'(ta2), 32'(m_gap > 0));
            if (m_own >= 0) chk($sformatf("rand%0d.owner", c), 32'(owner2), 32'(m_own));
            chk("rand.onehot", 32'($countones(grant2) <= 1), 1);
            chk("rand.busy_or", 32'(busy2), 32'(|grant2));
            if (ta2) begin
                ta_run++;
                chk("rand.turn_zero", 32'(grant2), 0);
            end else if (ta_run != 0) begin
                chk("rand.turn_len", 32'(ta_run), 32'(TURN2));
                ta_run = 0;
            end
            if (grant2 == 0) begin
                zero_run++;
            end else begin
                if (last_nz != 0 && grant2 != last_nz)
                    chk("rand.change_gap", 32'(zero_run >= TURN2), 1);
                last_nz = grant2;
                zero_run = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
Round-robin arbiter that shares one tristate bus among N requesters. Its registered one-hot grant vector drives the output-enable of each requester's tristate driver, so at most one driver is active at a time. A programmable turnaround gap with all drivers released (Z) separates consecutive owners. A hold limit caps bus occupancy when other requesters are waiting.

Parameters:
N, 4, number of requesters (2..8).
IDX_W, 2, width of the owner index; must satisfy 2**IDX_W >= N.
MAX_HOLD, 4, maximum consecutive grant cycles while another request is pending (>=1).
TURN, 1, number of all-released cycles between two owners (>=1).

Ports:
clock  input  1  system clock, rising edge.
reset_  input  1  asynchronous, active-low reset.
req  input  N  level request; bit i stays high while requester i wants the bus.
grant  output  N  registered one-hot or all-zero; bit i enables requester i's tristate driver.
owner  output  IDX_W  index of the current grant holder; valid only while busy=1.
busy  output  1  high when grant is nonzero.
turnaround  output  1  high during the TURN gap cycles.

Behaviour:
- One clock; reset is asynchronous and active-low (reset_).
- Reset values, applied immediately on reset_ low:
  - grant=0, owner=0, busy=0, turnaround=0
  - state=IDLE, hold_cnt=0, turn_cnt=0
  - last_owner=N-1, so requester 0 has top priority after reset.
- All outputs are registered. req is sampled on the rising edge.
- Invariant: grant is always one-hot or zero. busy equals the OR of grant. grant is 0 whenever turnaround=1.
- Round-robin: search starts at (last_owner+1) mod N and ascends with wrap. The first set req bit wins.
- States:
  - IDLE: grant=0. If any req bit is set at an edge, go to GRANT; the winner's grant appears after that edge (latency 1 cycle). Set hold_cnt=1 and last_owner=winner.
  - GRANT:
    - Release: req[owner]=0 at an edge -> go to TURN.
    - Preempt: req[owner]=1, hold_cnt==MAX_HOLD, and any other req bit set -> go to TURN.
    - Otherwise stay. hold_cnt increments and saturates at MAX_HOLD; with no competitor the owner keeps the bus indefinitely.
  - TURN: grant=0, turnaround=1, for exactly TURN cycles (turn_cnt counts 1..TURN).
    - At the edge that ends the last TURN cycle, arbitrate on current req.
    - If a winner exists, go to GRANT with the winner and hold_cnt=1; otherwise go to IDLE.
    - The previous owner is eligible but has lowest priority.
- A preempted owner that still holds req is re-queued at lowest priority.
- Gap between two consecutive owners is exactly TURN cycles of grant=0. From IDLE there is no gap.
- Requests raised or dropped during TURN are evaluated only at the arbitration edge.
- Reset asserted mid-operation: all drivers are released at once (grant=0 asynchronously). After reset_ deasserts, arbitration restarts from IDLE with requester 0 at top priority.
- Widths:
  - hold_cnt is wide enough to hold MAX_HOLD; turn_cnt is wide enough to hold TURN.
  - Index arithmetic wraps modulo N, not modulo 2**IDX_W.

Test Plan:
1. Single request: reset, then req=0100 -> after next edge grant=0100, owner=2, busy=1. req drops -> grant=0000, turnaround=1 for 1 cycle, then IDLE with busy=0.
2. Simultaneous requests (N=4, TURN=1): req=1011 held after reset -> grant 0001. Drop req0 -> 1 zero cycle, then 0010. Drop req1 -> 1 zero cycle, then 1000. Owner order 0,1,3.
3. Preemption (MAX_HOLD=4): req0 held continuously, req2 raised during cycle 1 of the grant -> grant=0001 for 4 cycles, 1 turnaround cycle, then grant=0100. When req2 drops, req0 regains the bus after 1 gap.
4. Lone holder: req=0001 held 10 cycles -> grant=0001 for all 10 cycles, with no turnaround and no gaps.
5. Reset mid-grant: while grant=1000, drive reset_=0 between edges -> grant=0 and busy=0 immediately. After release with req=1001, grant=0001.
6. Invariant check with TURN=2: random req for 1000 cycles.
   - Every cycle: grant is one-hot or zero, and busy equals the OR of grant.
   - Every owner change is preceded by exactly 2 cycles of grant=0.
   - No owner holds the bus for more than 4 cycles while another req is pending.
